// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
// Holds the arbiter FSM state encoding, the default bus widths and the
// captured-request record used between handshake and memory access.
package dmem_pkg;

    localparam int DMEM_ADDR_W = 8;
    localparam int DMEM_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                   we;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// Handshake: a request transfers in the cycle where rX_valid && rX_ready;
// the requester holds valid/we/addr/wdata stable until then (dropping valid
// early abandons the request). rX_rsp_valid is a one-cycle pulse that cannot
// be back-pressured; rX_rdata is meaningful while it is high.
// slave  : arbiter side.
// master : requesters plus memory side.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) ();

    logic              r0_valid;
    logic              r0_ready;
    logic              r0_we;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wdata;
    logic              r0_rsp_valid;
    logic [DATA_W-1:0] r0_rdata;

    logic              r1_valid;
    logic              r1_ready;
    logic              r1_we;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata;
    logic              r1_rsp_valid;
    logic [DATA_W-1:0] r1_rdata;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_a;
    logic [DATA_W-1:0] mem_wd;
    logic [DATA_W-1:0] mem_rd;

    modport slave (
        input  r0_valid, r0_we, r0_addr, r0_wdata,
        output r0_ready, r0_rsp_valid, r0_rdata,
        input  r1_valid, r1_we, r1_addr, r1_wdata,
        output r1_ready, r1_rsp_valid, r1_rdata,
        output mem_we, mem_a, mem_wd,
        input  mem_rd
    );

    modport master (
        output r0_valid, r0_we, r0_addr, r0_wdata,
        input  r0_ready, r0_rsp_valid, r0_rdata,
        output r1_valid, r1_we, r1_addr, r1_wdata,
        input  r1_ready, r1_rsp_valid, r1_rdata,
        input  mem_we, mem_a, mem_wd,
        output mem_rd
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. Purely combinational: a lone valid requester
// wins; on a tie the requester that was not granted last wins. No grant is
// issued while enable is low.
module rr_arb2 (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last_grant,
    input  logic       enable,
    output logic [1:0] grant
);

    // One-hot grant selection.
    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (valid0 && valid1) begin
                grant = last_grant ? 2'b01 : 2'b10;
            end else if (valid0) begin
                grant = 2'b01;
            end else if (valid1) begin
                grant = 2'b10;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the CPU
// load/store unit (requester 0) and the DMA/debug port (requester 1).
// Handshake in cycle N, memory access in N+1, response pulse in N+2; a new
// request can be accepted during the response cycle, giving one access per
// two cycles. Optional grant counters are built when DMEM_ARB_STATS_EN is
// defined. state/last_grant expose the FSM for observation.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W
) (
    input  logic                 clk,
    input  logic                 rst,
    dmem_arbiter_if.slave        bus,
    output arb_state_e           state,
    output logic                 last_grant
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]          gnt_cnt0,
    output logic [15:0]          gnt_cnt1
`endif
);

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic              last_grant_q;
    logic              owner_q;
    dmem_req_t         req_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;
    logic [1:0]        grant;
    logic              hs;

    // Grants are only offered while not occupying the memory.
    rr_arb2 u_arb (
        .valid0     (bus.r0_valid),
        .valid1     (bus.r1_valid),
        .last_grant (last_grant_q),
        .enable     (state_q != ACCESS),
        .grant      (grant)
    );

    // ready equals grant and grant implies valid, so any grant is a handshake.
    assign hs         = |grant;
    assign state      = state_q;
    assign last_grant = last_grant_q;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: accept from IDLE/RESP, always one access cycle then respond.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, RESP: state_d = hs ? ACCESS : IDLE;
            ACCESS:     state_d = RESP;
            default:    state_d = IDLE;
        endcase
    end

    // Request capture and round-robin history, updated on every handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q        <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else if (hs) begin
            owner_q      <= grant[1];
            last_grant_q <= grant[1];
            if (grant[1]) begin
                req_q.we    <= bus.r1_we;
                req_q.addr  <= DMEM_ADDR_W'(bus.r1_addr);
                req_q.wdata <= DMEM_DATA_W'(bus.r1_wdata);
            end else begin
                req_q.we    <= bus.r0_we;
                req_q.addr  <= DMEM_ADDR_W'(bus.r0_addr);
                req_q.wdata <= DMEM_DATA_W'(bus.r0_wdata);
            end
        end
    end

    // Read data is sampled at the end of the access cycle into the owner's register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else if (state_q == ACCESS && !req_q.we) begin
            if (owner_q) begin
                rdata1_q <= bus.mem_rd;
            end else begin
                rdata0_q <= bus.mem_rd;
            end
        end
    end

    // Bus outputs; mem_a/mem_wd follow the captured request, which only
    // changes on a handshake, so they hold their values outside ACCESS.
    always_comb begin
        bus.r0_ready     = grant[0];
        bus.r1_ready     = grant[1];
        bus.r0_rsp_valid = (state_q == RESP) && !owner_q;
        bus.r1_rsp_valid = (state_q == RESP) && owner_q;
        bus.r0_rdata     = rdata0_q;
        bus.r1_rdata     = rdata1_q;
        bus.mem_we       = (state_q == ACCESS) && req_q.we;
        bus.mem_a        = ADDR_W'(req_q.addr);
        bus.mem_wd       = DATA_W'(req_q.wdata);
    end

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] cnt0_q;
    logic [15:0] cnt1_q;

    // Saturating per-requester grant counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (grant[0] && cnt0_q != 16'hFFFF) begin
                cnt0_q <= cnt0_q + 16'd1;
            end
            if (grant[1] && cnt1_q != 16'hFFFF) begin
                cnt1_q <= cnt1_q + 16'd1;
            end
        end
    end

    assign gnt_cnt0 = cnt0_q;
    assign gnt_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural memory and a
// transaction scoreboard that predicts every response (owner, cycle, data).
// Build with DMEM_ARB_STATS_EN defined to also exercise the grant counters.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    typedef struct packed {
        logic        owner;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] due;
    } txn_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    arb_state_e dbg_state;
    logic       dbg_last_grant;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] gnt_cnt0;
    logic [15:0] gnt_cnt1;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rsp_count = 0;
    int r0_ready_seen = 0;

    logic [31:0] mem_arr   [256] = '{default: '0};
    logic [31:0] model_mem [256] = '{default: '0};
    logic [31:0] model_rd0 = '0;
    logic [31:0] model_rd1 = '0;
    txn_t        exp_q[$];
    int          hs_owner_log[$];
    int          hs_cyc_log[$];

    dmem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    dmem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .state      (dbg_state),
        .last_grant (dbg_last_grant)
`ifdef DMEM_ARB_STATS_EN
        ,
        .gnt_cnt0   (gnt_cnt0),
        .gnt_cnt1   (gnt_cnt1)
`endif
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Behavioural memory: combinational read, synchronous write.
    assign bus.mem_rd = mem_arr[bus.mem_a];
    always @(posedge clk) begin
        if (bus.mem_we) mem_arr[bus.mem_a] <= bus.mem_wd;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: responses are checked first, then new handshakes are queued.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            model_rd0 = '0;
            model_rd1 = '0;
        end else begin
            if (bus.r0_rsp_valid || bus.r1_rsp_valid) begin
                rsp_count++;
                chk("rsp_onehot", 32'({bus.r0_rsp_valid, bus.r1_rsp_valid} != 2'b11), 32'd1);
                chk("rsp_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    txn_t        t;
                    logic [31:0] exp_d;
                    t = exp_q.pop_front();
                    chk("rsp_owner", 32'(bus.r1_rsp_valid), 32'(t.owner));
                    chk("rsp_cycle", 32'(cyc), t.due);
                    if (t.we) begin
                        model_mem[t.addr] = t.wdata;
                        exp_d = t.owner ? model_rd1 : model_rd0;
                    end else begin
                        exp_d = model_mem[t.addr];
                        if (t.owner) model_rd1 = exp_d;
                        else         model_rd0 = exp_d;
                    end
                    chk("rsp_rdata", t.owner ? bus.r1_rdata : bus.r0_rdata, exp_d);
                end
            end
            if (exp_q.size() != 0 && exp_q[0].due < 32'(cyc)) begin
                chk("rsp_missing", 32'(cyc), exp_q[0].due);
                void'(exp_q.pop_front());
            end
            if (bus.r0_ready || bus.r1_ready) begin
                chk("ready_onehot", 32'(bus.r0_ready && bus.r1_ready), 32'd0);
            end
            if (bus.r0_ready) r0_ready_seen++;
            if (bus.r0_valid && bus.r0_ready) begin
                exp_q.push_back('{1'b0, bus.r0_we, bus.r0_addr, bus.r0_wdata, 32'(cyc + 2)});
                hs_owner_log.push_back(0);
                hs_cyc_log.push_back(cyc);
            end
            if (bus.r1_valid && bus.r1_ready) begin
                exp_q.push_back('{1'b1, bus.r1_we, bus.r1_addr, bus.r1_wdata, 32'(cyc + 2)});
                hs_owner_log.push_back(1);
                hs_cyc_log.push_back(cyc);
            end
        end
    end

    // Drive one request and hold it until accepted.
    task automatic issue(input int who, input logic we, input logic [7:0] addr, input logic [31:0] wdata);
        logic got;
        got = 1'b0;
        @(posedge clk); #1;
        if (who == 0) begin
            bus.r0_valid = 1'b1; bus.r0_we = we; bus.r0_addr = addr; bus.r0_wdata = wdata;
        end else begin
            bus.r1_valid = 1'b1; bus.r1_we = we; bus.r1_addr = addr; bus.r1_wdata = wdata;
        end
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = (who == 0) ? bus.r0_ready : bus.r1_ready;
        end
        chk("issue_ready", 32'(got), 32'd1);
        @(posedge clk); #1;
        if (who == 0) bus.r0_valid = 1'b0;
        else          bus.r1_valid = 1'b0;
    endtask

    // Wait for a response on one requester and compare its data.
    task automatic wait_rsp(input int who, input logic [31:0] exp, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = (who == 0) ? bus.r0_rsp_valid : bus.r1_rsp_valid;
        end
        chk({tag, "_seen"}, 32'(seen), 32'd1);
        if (seen) chk(tag, (who == 0) ? bus.r0_rdata : bus.r1_rdata, exp);
    endtask

    // Let all outstanding accesses complete.
    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    // Directed sequence.
    initial begin
        int base;
        int seen0;
        logic got;
        logic [31:0] d;

        bus.r0_valid = 1'b0; bus.r0_we = 1'b0; bus.r0_addr = '0; bus.r0_wdata = '0;
        bus.r1_valid = 1'b0; bus.r1_we = 1'b0; bus.r1_addr = '0; bus.r1_wdata = '0;

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_r0_ready", 32'(bus.r0_ready), 32'd0);
        chk("rst_r1_ready", 32'(bus.r1_ready), 32'd0);
        chk("rst_rsp", 32'({bus.r0_rsp_valid, bus.r1_rsp_valid}), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_a", 32'(bus.mem_a), 32'd0);
        chk("rst_mem_wd", bus.mem_wd, 32'd0);
        chk("rst_rdata0", bus.r0_rdata, 32'd0);
        chk("rst_rdata1", bus.r1_rdata, 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        chk("rst_last_grant", 32'(dbg_last_grant), 32'd1);

        // r0 write 06 <= DEADBEEF, cycle-exact latency.
        rst = 1'b0;
        bus.r0_valid = 1'b1; bus.r0_we = 1'b1; bus.r0_addr = 8'h06; bus.r0_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("t1_c0_r0_ready", 32'(bus.r0_ready), 32'd1);
        chk("t1_c0_r1_ready", 32'(bus.r1_ready), 32'd0);
        @(posedge clk); #1;
        bus.r0_valid = 1'b0;
        @(negedge clk);
        chk("t1_c1_mem_we", 32'(bus.mem_we), 32'd1);
        chk("t1_c1_mem_a", 32'(bus.mem_a), 32'h06);
        chk("t1_c1_mem_wd", bus.mem_wd, 32'hDEADBEEF);
        chk("t1_c1_state", 32'(dbg_state), 32'(ACCESS));
        @(negedge clk);
        chk("t1_c2_rsp", 32'(bus.r0_rsp_valid), 32'd1);
        chk("t1_c2_mem_we", 32'(bus.mem_we), 32'd0);
        chk("t1_c2_mem_a_hold", 32'(bus.mem_a), 32'h06);
        @(negedge clk);
        chk("t1_c3_rsp_oneshot", 32'(bus.r0_rsp_valid), 32'd0);
        issue(0, 1'b0, 8'h06, 32'h0);
        wait_rsp(0, 32'hDEADBEEF, "t1_read");
        drain();

        // Both requesters hold reads from reset: grants alternate every 2 cycles.
        @(posedge clk); #1;
        rst = 1'b1;
        bus.r0_valid = 1'b1; bus.r0_we = 1'b0; bus.r0_addr = 8'h06;
        bus.r1_valid = 1'b1; bus.r1_we = 1'b0; bus.r1_addr = 8'h10;
        base = hs_owner_log.size();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        bus.r0_valid = 1'b0;
        bus.r1_valid = 1'b0;
        drain();
        chk("t2_count", 32'(hs_owner_log.size() - base), 32'd6);
        if (hs_owner_log.size() >= base + 6) begin
            for (int i = 0; i < 6; i++) chk("t2_owner", 32'(hs_owner_log[base + i]), 32'(i % 2));
            for (int i = 1; i < 6; i++) chk("t2_spacing", 32'(hs_cyc_log[base + i] - hs_cyc_log[base + i - 1]), 32'd2);
        end

        // Same-cycle r0 read and r1 write of 10: r0 first sees the old value.
        pulse_reset();
        bus.r0_valid = 1'b1; bus.r0_we = 1'b0; bus.r0_addr = 8'h10;
        bus.r1_valid = 1'b1; bus.r1_we = 1'b1; bus.r1_addr = 8'h10; bus.r1_wdata = 32'h12345678;
        @(negedge clk);
        chk("t3_r0_first", 32'(bus.r0_ready), 32'd1);
        chk("t3_r1_wait", 32'(bus.r1_ready), 32'd0);
        @(posedge clk); #1;
        bus.r0_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (bus.r0_rsp_valid) chk("t3_old", bus.r0_rdata, 32'h0);
            got = bus.r1_ready;
        end
        chk("t3_r1_ready", 32'(got), 32'd1);
        @(posedge clk); #1;
        bus.r1_valid = 1'b0;
        drain();
        issue(0, 1'b0, 8'h10, 32'h0);
        wait_rsp(0, 32'h12345678, "t3_new");
        drain();

        // Reset during the access cycle of a write drops it.
        pulse_reset();
        bus.r0_valid = 1'b1; bus.r0_we = 1'b1; bus.r0_addr = 8'h20; bus.r0_wdata = 32'hAAAA5555;
        @(negedge clk);
        chk("t4_ready", 32'(bus.r0_ready), 32'd1);
        @(posedge clk); #1;
        bus.r0_valid = 1'b0;
        chk("t4_access_we", 32'(bus.mem_we), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t4_we_drop", 32'(bus.mem_we), 32'd0);
        chk("t4_state", 32'(dbg_state), 32'(IDLE));
        chk("t4_last_grant", 32'(dbg_last_grant), 32'd1);
        base = rsp_count;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("t4_no_rsp", 32'(rsp_count - base), 32'd0);
        chk("t4_mem_untouched", mem_arr[8'h20], 32'h0);

        // r1 alone, five back-to-back requests.
        pulse_reset();
        base = hs_owner_log.size();
        seen0 = r0_ready_seen;
        bus.r1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            d = $urandom_range(32'h7FFF_FFFF, 32'h1000_0000);
            bus.r1_we = (i < 3);
            bus.r1_addr = (i < 3) ? 8'(8'h30 + i) : 8'(8'h30 + i - 3);
            bus.r1_wdata = d;
            got = 1'b0;
            for (int k = 0; k < 10 && !got; k++) begin
                @(negedge clk);
                got = bus.r1_ready;
            end
            chk("t5_ready", 32'(got), 32'd1);
            @(posedge clk); #1;
        end
        bus.r1_valid = 1'b0;
        drain();
        chk("t5_count", 32'(hs_owner_log.size() - base), 32'd5);
        if (hs_owner_log.size() >= base + 5) begin
            for (int i = 0; i < 5; i++) chk("t5_owner", 32'(hs_owner_log[base + i]), 32'd1);
            for (int i = 1; i < 5; i++) chk("t5_spacing", 32'(hs_cyc_log[base + i] - hs_cyc_log[base + i - 1]), 32'd2);
        end
        chk("t5_r0_ready_low", 32'(r0_ready_seen - seen0), 32'd0);

`ifdef DMEM_ARB_STATS_EN
        // Grant counters and saturation.
        pulse_reset();
        chk("t6_rst_cnt0", 32'(gnt_cnt0), 32'd0);
        for (int i = 0; i < 3; i++) issue(0, 1'b0, 8'(i), 32'h0);
        for (int i = 0; i < 2; i++) issue(1, 1'b0, 8'(i), 32'h0);
        drain();
        chk("t6_cnt0", 32'(gnt_cnt0), 32'd3);
        chk("t6_cnt1", 32'(gnt_cnt1), 32'd2);
        @(posedge clk); #1;
        force dut.cnt0_q = 16'hFFFF;
        @(posedge clk); #1;
        release dut.cnt0_q;
        issue(0, 1'b0, 8'h00, 32'h0);
        drain();
        chk("t6_sat", 32'(gnt_cnt0), 32'h0000FFFF);
`endif

        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
